// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: IF_EXC_VECTOR_EN (adds the DROP state and exception redirect).
package if_fetch_stage_pkg;

  localparam int INSN_W = 32;

  localparam logic [INSN_W-1:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [INSN_W-1:0] EXC_VECTOR_DEF   = 32'h8000_0180;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
`ifdef IF_EXC_VECTOR_EN
    S_DROP  = 2'd2,
`endif
    S_HOLD  = 2'd1
  } state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic              IMem_Req;
  logic [INSN_W-1:0] IMem_Addr;
  logic              IMem_Ready;
  logic [INSN_W-1:0] IMem_RData;

  modport master (output IMem_Req, IMem_Addr, input IMem_Ready, IMem_RData);
  modport slave  (input IMem_Req, IMem_Addr, output IMem_Ready, IMem_RData);
endinterface

// File: rtl/if_fetch_stage_pc_sel.sv
// if_pc_sel: PC register, next-PC selection and the pending branch redirect.
// Optional feature macro: IF_EXC_VECTOR_EN (exception redirect to EXC_VECTOR).
module if_pc_sel
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INSN_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef IF_EXC_VECTOR_EN
  , parameter logic [INSN_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept_i,
  input  logic              branch_i,
  input  logic [INSN_W-1:0] branch_target_i,
`ifdef IF_EXC_VECTOR_EN
  input  logic              exc_i,
`endif
  output logic [INSN_W-1:0] pc_o,
  output logic [INSN_W-1:0] pc_plus4_o
);

  logic [INSN_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic              pend_q, pend_d;

  // Wraps naturally at 2^32; misaligned PCs pass through untouched.
  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_o       = pc_q;

  // Next PC: a same-cycle branch beats a remembered one, which beats sequential.
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (accept_i) begin
      pc_d   = branch_i ? branch_target_i : (pend_q ? tgt_q : pc_plus4_o);
      pend_d = 1'b0;
    end else if (branch_i) begin
      // Delay slot not consumed yet: park the target until it is.
      pend_d = 1'b1;
      tgt_d  = branch_target_i;
    end
`ifdef IF_EXC_VECTOR_EN
    if (exc_i) begin
      pc_d   = EXC_VECTOR;
      pend_d = 1'b0;
    end
`endif
  end

  // PC / pending redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_VECTOR;
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: FETCH/HOLD(/DROP) control around the instruction
// memory bus, buffering a word while ID stalls, and flush/stall to IF/ID.
// Optional feature macro: IF_EXC_VECTOR_EN (Exception port, DROP state).
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INSN_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef IF_EXC_VECTOR_EN
  , parameter logic [INSN_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  if_fetch_stage_if.master  imem,
  input  logic              ID_Stall,
  input  logic              Branch,
  input  logic [INSN_W-1:0] BranchTarget,
  input  logic              FlushReq,
`ifdef IF_EXC_VECTOR_EN
  input  logic              Exception,
`endif
  output logic [INSN_W-1:0] Instruction,
  output logic [INSN_W-1:0] PCAdd4,
  output logic [INSN_W-1:0] PCOut,
  output logic              IF_Stall,
  output logic              IF_Flush
);

  state_e            state_q, state_d;
  logic [INSN_W-1:0] buf_q, buf_d, pc;
  logic              in_fetch, in_hold, req, valid, accept, exc;

  // Reset masks everything: no request, no valid, no flush.
  assign in_fetch = !RST && (state_q == S_FETCH);
  assign in_hold  = !RST && (state_q == S_HOLD);
  assign req      = !RST && (state_q != S_HOLD);
  assign valid    = (in_fetch && imem.IMem_Ready) || in_hold;
  assign accept   = valid && !ID_Stall;

`ifdef IF_EXC_VECTOR_EN
  assign exc = Exception && !RST;
`else
  assign exc = 1'b0;
`endif

  if_pc_sel #(
    .RESET_VECTOR   (RESET_VECTOR)
`ifdef IF_EXC_VECTOR_EN
    , .EXC_VECTOR   (EXC_VECTOR)
`endif
  ) u_pc_sel (
    .clk_i          (CLK),
    .rst_i          (RST),
    .accept_i       (accept),
    .branch_i       (Branch),
    .branch_target_i(BranchTarget),
`ifdef IF_EXC_VECTOR_EN
    .exc_i          (exc),
`endif
    .pc_o           (pc),
    .pc_plus4_o     (PCAdd4)
  );

  // Next state: buffer a returned word while ID holds, release it on accept.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      S_FETCH: if (imem.IMem_Ready && ID_Stall) begin
        state_d = S_HOLD;
        buf_d   = imem.IMem_RData;
      end
      S_HOLD:  if (accept) state_d = S_FETCH;
`ifdef IF_EXC_VECTOR_EN
      S_DROP:  if (imem.IMem_Ready) state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase
`ifdef IF_EXC_VECTOR_EN
    // An in-flight request must be waited out before refetching.
    if (exc) state_d = (req && !imem.IMem_Ready) ? S_DROP : S_FETCH;
`endif
  end

  // FSM state and hold buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

`ifdef IF_EXC_VECTOR_EN
  logic [INSN_W-1:0] drop_addr_q;

  // Freeze the address of the abandoned request for the length of DROP.
  always_ff @(posedge CLK) begin
    if (RST)                    drop_addr_q <= '0;
    else if (state_q != S_DROP) drop_addr_q <= pc;
  end

  assign imem.IMem_Addr = (state_q == S_DROP) ? drop_addr_q : pc;
`else
  assign imem.IMem_Addr = pc;
`endif

  assign imem.IMem_Req = req;
  assign Instruction   = in_fetch ? imem.IMem_RData : (in_hold ? buf_q : '0);
  assign PCOut         = pc;
  assign IF_Stall      = !valid;
  assign IF_Flush      = (FlushReq && valid) || exc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed vector table, exception sequence
// (when IF_EXC_VECTOR_EN is defined) and randomized stream-level model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, ID_Stall, Branch, FlushReq;
  logic [31:0] BranchTarget, Instruction, PCAdd4, PCOut;
  logic        IF_Stall, IF_Flush;
`ifdef IF_EXC_VECTOR_EN
  logic        exc_s, exc_next;
`endif

  int checks = 0;
  int failures = 0;

  if_fetch_stage_if imem();

  if_fetch_stage dut (
    .CLK(CLK), .RST(RST), .imem(imem),
    .ID_Stall(ID_Stall), .Branch(Branch), .BranchTarget(BranchTarget),
    .FlushReq(FlushReq),
`ifdef IF_EXC_VECTOR_EN
    .Exception(exc_s),
`endif
    .Instruction(Instruction), .PCAdd4(PCAdd4), .PCOut(PCOut),
    .IF_Stall(IF_Stall), .IF_Flush(IF_Flush)
  );

  always #5 CLK = ~CLK;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // One cycle: drive just after posedge, return at negedge for sampling.
  task automatic drive(input logic rst, input logic rdy, input logic stall,
                       input logic br, input logic [31:0] tgt, input logic fl);
    @(posedge CLK); #1;
    RST = rst; ID_Stall = stall; Branch = br; BranchTarget = tgt; FlushReq = fl;
`ifdef IF_EXC_VECTOR_EN
    exc_s = exc_next;
`endif
    imem.IMem_Ready = rdy;
    imem.IMem_RData = rdy ? hash(imem.IMem_Addr) : 32'hDEAD_BEEF;
    @(negedge CLK);
  endtask

  // ctl = {rst, rdy, stall, br, flush}; ex = {req, if_stall, if_flush}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] tgt;
    logic [2:0]  ex;
    logic [31:0] addr;
  } vec_t;

  vec_t tv[30];

  logic        m_held, m_pend, m_valid, r_rdy, r_stall, r_br, r_fl;
  logic [31:0] m_pc, m_ptgt, r_tgt;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; ID_Stall = 1'b0; Branch = 1'b0; BranchTarget = '0; FlushReq = 1'b0;
    imem.IMem_Ready = 1'b0; imem.IMem_RData = '0;
`ifdef IF_EXC_VECTOR_EN
    exc_s = 1'b0; exc_next = 1'b0;
`endif
    tv[0]  = '{5'b11000, 32'h0,          3'b010, 32'hBFC0_0000};
    tv[1]  = '{5'b01000, 32'h0,          3'b100, 32'hBFC0_0000};
    tv[2]  = '{5'b01000, 32'h0,          3'b100, 32'hBFC0_0004};
    tv[3]  = '{5'b01000, 32'h0,          3'b100, 32'hBFC0_0008};
    tv[4]  = '{5'b00000, 32'h0,          3'b110, 32'hBFC0_000C};
    tv[5]  = '{5'b00000, 32'h0,          3'b110, 32'hBFC0_000C};
    tv[6]  = '{5'b00000, 32'h0,          3'b110, 32'hBFC0_000C};
    tv[7]  = '{5'b01100, 32'h0,          3'b100, 32'hBFC0_000C};
    tv[8]  = '{5'b00100, 32'h0,          3'b000, 32'hBFC0_000C};
    tv[9]  = '{5'b00000, 32'h0,          3'b000, 32'hBFC0_000C};
    tv[10] = '{5'b01000, 32'h0,          3'b100, 32'hBFC0_0010};
    tv[11] = '{5'b00110, 32'h0040_0100,  3'b110, 32'hBFC0_0014};
    tv[12] = '{5'b01100, 32'h0,          3'b100, 32'hBFC0_0014};
    tv[13] = '{5'b00000, 32'h0,          3'b000, 32'hBFC0_0014};
    tv[14] = '{5'b01000, 32'h0,          3'b100, 32'h0040_0100};
    tv[15] = '{5'b01001, 32'h0,          3'b101, 32'h0040_0104};
    tv[16] = '{5'b00001, 32'h0,          3'b110, 32'h0040_0108};
    tv[17] = '{5'b01000, 32'h0,          3'b100, 32'h0040_0108};
    tv[18] = '{5'b01010, 32'hFFFF_FFFC,  3'b100, 32'h0040_010C};
    tv[19] = '{5'b01000, 32'h0,          3'b100, 32'hFFFF_FFFC};
    tv[20] = '{5'b01000, 32'h0,          3'b100, 32'h0000_0000};
    tv[21] = '{5'b00010, 32'h0000_1000,  3'b110, 32'h0000_0004};
    tv[22] = '{5'b00010, 32'h0000_2000,  3'b110, 32'h0000_0004};
    tv[23] = '{5'b01000, 32'h0,          3'b100, 32'h0000_0004};
    tv[24] = '{5'b01000, 32'h0,          3'b100, 32'h0000_2000};
    tv[25] = '{5'b01010, 32'h0000_3003,  3'b100, 32'h0000_2004};
    tv[26] = '{5'b01000, 32'h0,          3'b100, 32'h0000_3003};
    tv[27] = '{5'b00000, 32'h0,          3'b110, 32'h0000_3007};
    tv[28] = '{5'b11001, 32'h0,          3'b010, 32'h0000_3007};
    tv[29] = '{5'b01000, 32'h0,          3'b100, 32'hBFC0_0000};

    repeat (2) @(posedge CLK);

    // Directed table
    for (int i = 0; i < 30; i++) begin
      drive(tv[i].ctl[4], tv[i].ctl[3], tv[i].ctl[2], tv[i].ctl[1], tv[i].tgt, tv[i].ctl[0]);
      chk1 ($sformatf("v%0d.req", i),   imem.IMem_Req, tv[i].ex[2]);
      chk1 ($sformatf("v%0d.stall", i), IF_Stall,      tv[i].ex[1]);
      chk1 ($sformatf("v%0d.flush", i), IF_Flush,      tv[i].ex[0]);
      chk32($sformatf("v%0d.addr", i),  imem.IMem_Addr, tv[i].addr);
      chk32($sformatf("v%0d.pc", i),    PCOut,          tv[i].addr);
      if (tv[i].ctl[4])
        chk32($sformatf("v%0d.insn_rst", i), Instruction, 32'h0);
      else if (!tv[i].ex[1]) begin
        chk32($sformatf("v%0d.insn", i),  Instruction, hash(tv[i].addr));
        chk32($sformatf("v%0d.pc4", i),   PCAdd4,      tv[i].addr + 32'd4);
      end
    end

`ifdef IF_EXC_VECTOR_EN
    // Exception while a request is outstanding: old word discarded.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1 ("exc.c1.req", imem.IMem_Req, 1'b1);
    chk1 ("exc.c1.stall", IF_Stall, 1'b1);
    exc_next = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    exc_next = 1'b0;
    chk1 ("exc.c2.flush", IF_Flush, 1'b1);
    chk1 ("exc.c2.stall", IF_Stall, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1 ("exc.drop.req", imem.IMem_Req, 1'b1);
    chk32("exc.drop.addr", imem.IMem_Addr, 32'hBFC0_0000);
    chk32("exc.drop.pc", PCOut, 32'h8000_0180);
    chk32("exc.drop.insn", Instruction, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1 ("exc.discard.stall", IF_Stall, 1'b1);
    chk1 ("exc.discard.flush", IF_Flush, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk32("exc.new.addr", imem.IMem_Addr, 32'h8000_0180);
    chk32("exc.new.pc", PCOut, 32'h8000_0180);
    chk1 ("exc.new.stall", IF_Stall, 1'b0);
    chk32("exc.new.insn", Instruction, hash(32'h8000_0180));
    exc_next = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    exc_next = 1'b0;
    chk1 ("exc.valid.flush", IF_Flush, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk32("exc.valid.addr", imem.IMem_Addr, 32'h8000_0180);
    chk1 ("exc.valid.stall", IF_Stall, 1'b0);
`endif

    // Randomized run against a delivered-instruction-stream model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    m_pc = 32'hBFC0_0000; m_pend = 1'b0; m_ptgt = '0; m_held = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r_rdy   = (($urandom % 3) != 0) && !m_held;
      r_stall = ($urandom % 4) == 0;
      r_br    = ($urandom % 8) == 0;
      r_tgt   = $urandom & 32'h000F_FFFC;
      r_fl    = ($urandom % 5) == 0;
      drive(1'b0, r_rdy, r_stall, r_br, r_tgt, r_fl);
      m_valid = m_held || r_rdy;
      chk1 ("rnd.req", imem.IMem_Req, !m_held);
      if (!m_held) chk32("rnd.addr", imem.IMem_Addr, m_pc);
      chk32("rnd.pc", PCOut, m_pc);
      chk32("rnd.pc4", PCAdd4, m_pc + 32'd4);
      chk1 ("rnd.stall", IF_Stall, !m_valid);
      chk1 ("rnd.flush", IF_Flush, r_fl && m_valid);
      if (m_valid) chk32("rnd.insn", Instruction, hash(m_pc));
      if (m_valid && !r_stall) begin
        m_pc   = r_br ? r_tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend = 1'b0;
        m_held = 1'b0;
      end else begin
        if (m_valid) m_held = 1'b1;
        if (r_br) begin
          m_pend = 1'b1;
          m_ptgt = r_tgt;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
